// File: rtl/ipml_prefetch_fifo_pkg.sv
// ipml_prefetch_fifo_pkg: shared constants and parameter checks for the prefetch FIFO
package ipml_prefetch_fifo_pkg;

    localparam int SKID_DEPTH = 2;

    // Occupancy spans 0..2^depth_w + SKID_DEPTH.
    function automatic int occ_w(input int depth_w);
        return depth_w + 2;
    endfunction

    function automatic bit params_ok(input int data_w, input int depth_w, input int af, input int ae);
        return data_w >= 1 && data_w <= 1152 && depth_w >= 4 && depth_w <= 16 &&
               af >= 0 && af <= (1 << depth_w) + SKID_DEPTH &&
               ae >= 0 && ae <= (1 << depth_w) + SKID_DEPTH;
    endfunction

endpackage

// File: rtl/ipml_prefetch_skid_v2_0.sv
// ipml_prefetch_skid_v2_0: 2-entry register FIFO holding the head words behind the RAM
module ipml_prefetch_skid_v2_0
    import ipml_prefetch_fifo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_rdy,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        cnt
);

    localparam logic [1:0] FULL = 2'(SKID_DEPTH);

    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic              push, pop;

    // The producer only pushes when space is guaranteed, so a push is never refused.
    // e0 is the head; it only changes when a new head arrives, so it is stable while empty.
    always_comb begin
        push  = in_vld & ~flush;
        pop   = out_rdy & (cnt_q != 2'd0) & ~flush;
        cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
        e0_d  = (push & ((cnt_q == 2'd0) | ((cnt_q == 2'd1) & pop))) ? in_data :
                (pop & (cnt_q == FULL)) ? e1_q : e0_q;
        e1_d  = (push & (((cnt_q == 2'd1) & ~pop) | ((cnt_q == FULL) & pop))) ? in_data : e1_q;
    end

    // State registers; data cleared on reset so rd_data is never unknown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign out_vld  = cnt_q != 2'd0;
    assign out_data = e0_q;
    assign cnt      = cnt_q;

endmodule

// File: rtl/ipml_prefetch_sfifo_v2_0.sv
// ipml_prefetch_sfifo_v2_0: synchronous FWFT FIFO, block RAM plus a 2-word prefetch skid
module ipml_prefetch_sfifo_v2_0
    import ipml_prefetch_fifo_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH_W  = 10,
    parameter int AF_LEVEL = (1 << DEPTH_W) - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 wr_en,
    output logic                 wr_vld,
    output logic [DATA_W-1:0]    rd_data,
    input  logic                 rd_en,
    output logic                 rd_vld,
    output logic [DEPTH_W+1:0]   level,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int             LW   = occ_w(DEPTH_W);
    localparam int             AW   = DEPTH_W;
    localparam logic [LW-1:0]  AF_L = LW'(AF_LEVEL);
    localparam logic [LW-1:0]  AE_L = LW'(AE_LEVEL);

    if (!params_ok(DATA_W, DEPTH_W, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("ipml_prefetch_sfifo_v2_0: illegal parameter combination");
    end

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];
    logic [DATA_W-1:0] ram_dout_q;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic              inflight_q, inflight_d;
    logic [LW-1:0]     level_q, level_d;
    logic              af_q, af_d, ae_q, ae_d, ovf_q, ovf_d, udf_q, udf_d;
    logic              wr_acc, pop, issue;
    logic [1:0]        skid_cnt, skid_cnt_d;

    // Pointer/count bookkeeping; a RAM read is issued only if the skid can absorb it.
    always_comb begin
        wr_vld     = ~cnt_q[AW];
        wr_acc     = wr_en & wr_vld & ~flush;
        pop        = rd_en & rd_vld & ~flush;
        issue      = ~flush & (cnt_q != '0) &
                     (({1'b0, skid_cnt} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
        wr_ptr_d   = flush ? '0 : wr_ptr_q + AW'(wr_acc);
        rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(issue);
        cnt_d      = flush ? '0 : cnt_q + (AW+1)'(wr_acc) - (AW+1)'(issue);
        inflight_d = issue;
        skid_cnt_d = flush ? 2'd0 : skid_cnt + {1'b0, inflight_q} - {1'b0, pop};
        level_d    = LW'(cnt_d) + LW'(inflight_d) + LW'(skid_cnt_d);
        af_d       = level_d >= AF_L;
        ae_d       = level_d <= AE_L;
        ovf_d      = wr_en & ~wr_vld;
        udf_d      = rd_en & ~rd_vld;
    end

    // Control and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            level_q    <= '0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            level_q    <= level_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Storage RAM with registered read; pointers never collide so no bypass is needed.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_q] <= wr_data;
        if (issue) ram_dout_q <= mem[rd_ptr_q];
    end

    ipml_prefetch_skid_v2_0 #(.DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (inflight_q),
        .in_data  (ram_dout_q),
        .out_rdy  (rd_en),
        .out_vld  (rd_vld),
        .out_data (rd_data),
        .cnt      (skid_cnt)
    );

    assign level        = level_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_ipml_prefetch_sfifo_v2_0.sv
// tb_ipml_prefetch_sfifo_v2_0: directed and random checks against an occupancy/queue model
module tb_ipml_prefetch_sfifo_v2_0;

    localparam int DW = 8, AW = 4, DEPTH = 16, AF = 12, AE = 4;

    logic          clk = 1'b0, rst_n = 1'b1, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_vld, rd_vld, almost_full, almost_empty, overflow, underflow;
    logic [DW-1:0] rd_data;
    logic [AW+1:0] level;

    ipml_prefetch_sfifo_v2_0 #(.DATA_W(DW), .DEPTH_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
        .wr_vld(wr_vld), .rd_data(rd_data), .rd_en(rd_en), .rd_vld(rd_vld), .level(level),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    logic [DW-1:0] q[$];
    int m_ram = 0, m_infl = 0, m_skid = 0;
    bit m_ovf = 0, m_udf = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_level();
        return m_ram + m_infl + m_skid;
    endfunction

    task automatic check_all();
        chk("rd_vld", rd_vld, m_skid > 0);
        chk("wr_vld", wr_vld, m_ram < DEPTH);
        chk("level", level, m_level());
        chk("almost_full", almost_full, m_level() >= AF);
        chk("almost_empty", almost_empty, m_level() <= AE);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_udf);
        if (m_skid > 0) chk("rd_data", rd_data, q[0]);
    endtask

    task automatic model_edge();
        int wr, pop, iss;
        m_ovf = wr_en && m_ram >= DEPTH;
        m_udf = rd_en && m_skid == 0;
        if (flush) begin
            q.delete();
            m_ram = 0; m_infl = 0; m_skid = 0;
        end else begin
            wr  = (wr_en && m_ram < DEPTH) ? 1 : 0;
            pop = (rd_en && m_skid > 0) ? 1 : 0;
            iss = (m_ram > 0 && m_skid + m_infl - pop < 2) ? 1 : 0;
            if (pop == 1) void'(q.pop_front());
            if (wr == 1) q.push_back(wr_data);
            m_skid = m_skid + m_infl - pop;
            m_infl = iss;
            m_ram  = m_ram + wr - iss;
        end
    endtask

    task automatic cyc(input bit we, input logic [DW-1:0] wd, input bit re, input bit fl);
        wr_en = we; wr_data = wd; rd_en = re; flush = fl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ram = 0; m_infl = 0; m_skid = 0; m_ovf = 0; m_udf = 0;
        check_all();
        chk("rst_rd_data", rd_data, 0);
        @(negedge clk);
        wr_en = 0; rd_en = 0; flush = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first;
        #2;
        do_reset();
        // single word latency
        cyc(1, 8'hA5, 0, 0);
        cyc(0, 0, 0, 0);
        chk("a5_vld_edge2", rd_vld, 0);
        cyc(0, 0, 0, 0);
        chk("a5_vld", rd_vld, 1);
        chk("a5_data", rd_data, 8'hA5);
        chk("a5_level", level, 1);
        chk("a5_ae", almost_empty, 1);
        cyc(0, 0, 1, 0);
        // fill to 18 and overflow
        for (int i = 0; i < 18; i++) cyc(1, 8'(i), 0, 0);
        chk("full_wr_vld", wr_vld, 0);
        chk("full_level", level, 18);
        cyc(1, 8'hEE, 0, 0);
        chk("ovf_pulse", overflow, 1);
        cyc(0, 0, 0, 0);
        chk("ovf_clear", overflow, 0);
        // drain with rd_en held
        for (int i = 0; i < 18; i++) begin
            chk("drain_vld", rd_vld, 1);
            chk("drain_data", rd_data, i);
            cyc(0, 0, 1, 0);
        end
        chk("drain_empty", rd_vld, 0);
        cyc(0, 0, 1, 0);
        chk("udf_pulse", underflow, 1);
        // streaming, no bubbles after first valid
        first = -1;
        for (int i = 0; i < 100; i++) begin
            cyc(1, 8'(i), 1, 0);
            if (first >= 0) chk("no_bubble", rd_vld, 1);
            else if (rd_vld) first = i;
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0);
        chk("stream_drained", level, 0);
        // flush with concurrent write
        for (int i = 0; i < 10; i++) cyc(1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        cyc(1, 8'h77, 0, 1);
        chk("flush_level", level, 0);
        chk("flush_rd_vld", rd_vld, 0);
        chk("flush_wr_vld", wr_vld, 1);
        cyc(1, 8'h55, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("post_flush_data", rd_data, 8'h55);
        chk("post_flush_level", level, 1);
        // reset mid-stream with a read in flight
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h80 + i), 1, 0);
        do_reset();
        cyc(1, 8'h3C, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("post_rst_vld", rd_vld, 1);
        chk("post_rst_data", rd_data, 8'h3C);
        // random phases with varying pressure
        for (int p = 0; p < 6; p++) begin
            int wp, rp;
            wp = (p % 3 == 0) ? 90 : (p % 3 == 1) ? 30 : 60;
            rp = (p % 3 == 0) ? 30 : (p % 3 == 1) ? 90 : 60;
            if (p == 3) do_reset();
            for (int i = 0; i < 500; i++)
                cyc($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp,
                    $urandom_range(99) < 2);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ipml_prefetch_sfifo_v2_0.md
IPML_PREFETCH_SFIFO_V2_0 -- requirements
Module: ipml_prefetch_sfifo_v2_0

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits, legal range 1..1152.
REQ-002 SHALL have parameter DEPTH_W, default 10: the RAM holds 2^DEPTH_W words, legal range 4..16.
REQ-003 SHALL have parameter AF_LEVEL, default 2^DEPTH_W-4: almost_full threshold on occupancy.
REQ-004 SHALL have parameter AE_LEVEL, default 4: almost_empty threshold on occupancy.
REQ-005 SHALL have the following ports, listed as name / direction / width / meaning:
- clk / in / 1 / the single clock; all logic is on its rising edge.
- rst_n / in / 1 / asynchronous active-low reset.
- flush / in / 1 / synchronous clear.
- wr_data / in / DATA_W / write data.
- wr_en / in / 1 / write request.
- wr_vld / out / 1 / write ready; equals ~full.
- rd_data / out / DATA_W / head word, first-word-fall-through.
- rd_en / in / 1 / read request (ready).
- rd_vld / out / 1 / rd_data holds a valid word.
- level / out / DEPTH_W+2 / occupancy (REQ-010).
- almost_full / out / 1 / almost-full flag.
- almost_empty / out / 1 / almost-empty flag.
- overflow / out / 1 / registered one-cycle error pulse.
- underflow / out / 1 / registered one-cycle error pulse.

Function
REQ-006 SHALL accept a write on a rising edge exactly when wr_en & wr_vld & ~flush.
REQ-007 SHALL pop the head word on a rising edge exactly when rd_en & rd_vld & ~flush.
REQ-008 SHALL implement a storage RAM with 1-cycle synchronous read and wrapping DEPTH_W-bit read/write pointers, with no read-during-write bypass.
REQ-009 SHALL issue a RAM read in a cycle iff the RAM is non-empty and (skid_cnt + inflight - pop) < 2, where skid_cnt is 0..2 and inflight is 0..1.
REQ-010 SHALL define level = RAM words + inflight + skid_cnt, with range 0..2^DEPTH_W+2.
REQ-011 SHALL drive wr_vld = (RAM words < 2^DEPTH_W), so the output stage may hold 2 more words than the RAM.
REQ-012 SHALL, into an empty FIFO, assert rd_vld after the second rising edge following the accepting edge (write-to-rd_vld latency = 2 edges).
REQ-013 SHALL sustain one write and one pop per cycle at steady state, with no bubbles while level >= 3.
REQ-014 SHALL present rd_data in write order, holding it stable while rd_vld & ~rd_en.
REQ-015 SHALL keep rd_data unchanged when rd_vld=0; its value is then don't-care but must not be X after reset.
REQ-016 SHALL update almost_full = (level >= AF_LEVEL) and almost_empty = (level <= AE_LEVEL) from next-state level, registered.
REQ-017 SHALL pulse overflow for one cycle after an edge with wr_en & ~wr_vld, and underflow for one cycle after an edge with rd_en & ~rd_vld.
REQ-018 SHALL, on an edge with a simultaneous write and pop at full, accept both, because wr_vld depends only on the RAM count.
REQ-019 SHALL, on an edge with a simultaneous write and pop at empty RAM with one skid word, pop the skid word and write to RAM; the new word becomes visible per REQ-012.
REQ-020 SHALL treat flush=1 at an edge as follows: clear pointers, inflight, skid_cnt and level; discard concurrent wr_en/rd_en; set rd_vld=0 and wr_vld=1 on the next cycle.
REQ-021 SHALL discard a RAM read in flight at flush, so that it never reaches the skid.

Reset
REQ-022 SHALL, while rst_n=0 and asynchronously, drive rd_vld=0, rd_data=0, level=0, almost_full=0, almost_empty=1, overflow=0, underflow=0 and wr_vld=1.
REQ-023 SHALL make the RAM contents don't-care after reset; no read of a stale word may occur.
REQ-024 SHALL release reset synchronously, with the first write accepted on the first edge after rst_n rises.
REQ-025 SHALL make reset mid-operation equivalent to flush plus clearing of the flag registers.

Structure
REQ-026 SHALL place the shared constants in a package ipml_prefetch_fifo_pkg: the occupancy width function, the skid depth constant (2), and parameter legality checks.
REQ-027 SHALL contain exactly one sub-module, ipml_prefetch_skid_v2_0: a 2-entry valid/ready register FIFO of width DATA_W with an added flush input.
REQ-028 SHALL keep the RAM inferred inline, with no vendor primitive instantiation.

Verification (DATA_W=8, DEPTH_W=4)
REQ-029 SHALL cover: reset, then write 0xA5 at edge 1 -> rd_vld=1 and rd_data=0xA5 after edge 3; level=1; almost_empty=1.
REQ-030 SHALL cover: 18 writes of 0..17 with rd_en=0 -> writes 0..17 are accepted; wr_vld=0 after the 18th; level=18; the 19th write gives an overflow pulse.
REQ-031 SHALL cover: from full, 18 pops with rd_en held at 1 -> data 0..17 in order on consecutive cycles; then rd_vld=0; a further rd_en gives an underflow pulse.
REQ-032 SHALL cover: continuous write+read for 100 cycles of an incrementing pattern -> zero bubbles after the first rd_vld and ordered data across 6 pointer wraps.
REQ-033 SHALL cover: 10 words written, 3 popped, then flush together with wr_en=1 -> level=0, rd_vld=0 and wr_vld=1 next cycle; the flushed-cycle word is absent.
REQ-034 SHALL cover: rst_n low mid-stream with a read in flight -> all REQ-022 values are immediate, and the first post-reset write is read back correctly.
